// File: rtl/sti_dac_pkg.sv
// sti_dac_pkg: shared length encodings, frame helpers and FSM state types for sti_dac
package sti_dac_pkg;
  localparam logic [1:0] LEN_8  = 2'b00;
  localparam logic [1:0] LEN_16 = 2'b01;
  localparam logic [1:0] LEN_24 = 2'b10;
  localparam logic [1:0] LEN_32 = 2'b11;
  typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_WRITE, WR_FILL, WR_DONE} wr_state_t;
  function automatic logic [5:0] len_bits(input logic [1:0] len);
    return {({1'b0, len} + 3'd1), 3'b000};
  endfunction
  function automatic logic [31:0] build_frame(input logic [15:0] d, input logic [1:0] len,
                                              input logic fill, input logic low);
    return len == LEN_8  ? {24'h0, low ? d[15:8] : d[7:0]} :
           len == LEN_16 ? {16'h0, d} :
           len == LEN_24 ? (fill ? {8'h0, d, 8'h00} : {16'h0, d}) :
                           (fill ? {d, 16'h0000} : {16'h0, d});
  endfunction
endpackage

// File: rtl/sti_serializer.sv
// sti_serializer: builds a frame on load and shifts it out one bit per cycle with so_valid
module sti_serializer
  import sti_dac_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] pi_data,
  input  logic [1:0]  pi_length,
  input  logic        pi_fill,
  input  logic        pi_msb,
  input  logic        pi_low,
  output logic        so_data,
  output logic        so_valid
);
  ser_state_t  r_state, w_next;
  logic [31:0] r_frame, w_frame;
  logic [5:0]  r_cnt;
  logic        r_msb;
  always_comb begin
    w_frame = build_frame(pi_data, pi_length, pi_fill, pi_low);
    w_frame = pi_msb ? w_frame << (6'd32 - len_bits(pi_length)) : w_frame;
    w_next  = r_state == SER_IDLE ? (load ? SER_SHIFT : SER_IDLE) : (r_cnt == 6'd0 ? SER_IDLE : SER_SHIFT);
  end
  always_ff @(posedge clk)
    if (reset) r_state <= SER_IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk)
    if (reset) begin
      r_frame <= '0;
      r_cnt   <= '0;
      r_msb   <= 1'b0;
    end else if (r_state == SER_IDLE && load) begin
      r_frame <= w_frame;
      r_cnt   <= len_bits(pi_length) - 6'd1;
      r_msb   <= pi_msb;
    end else if (r_state == SER_SHIFT) begin
      r_frame <= r_msb ? r_frame << 1 : r_frame >> 1;
      r_cnt   <= r_cnt - 6'd1;
    end
  assign so_valid = r_state == SER_SHIFT;
  assign so_data  = so_valid & (r_msb ? r_frame[31] : r_frame[0]);
endmodule

// File: rtl/sti_dac.sv
// sti_dac: serial transmitter whose bit stream is packed into bytes and written to pixel memory
module sti_dac
  import sti_dac_pkg::*;
#(
  parameter int PIX_DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] pi_data,
  input  logic [1:0]  pi_length,
  input  logic        pi_fill,
  input  logic        pi_msb,
  input  logic        pi_low,
  input  logic        pi_end,
  output logic        so_data,
  output logic        so_valid,
  output logic [7:0]  pixel_addr,
  output logic [7:0]  pixel_dataout,
  output logic        pixel_wr,
  output logic        pixel_finish
);
  localparam logic [7:0] LAST = 8'(PIX_DEPTH - 1);
  wr_state_t  r_wst, w_next;
  logic [7:0] r_pack, r_dout, r_addr, w_pad;
  logic [2:0] r_pcnt;
  logic       r_ph, r_wr, r_finish;
  logic       w_busy, w_done_byte, w_partial, w_fill, w_last;
  sti_serializer u_ser (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .pi_data  (pi_data),
    .pi_length(pi_length),
    .pi_fill  (pi_fill),
    .pi_msb   (pi_msb),
    .pi_low   (pi_low),
    .so_data  (so_data),
    .so_valid (so_valid)
  );
  always_comb begin
    w_busy      = so_valid | load;
    w_done_byte = so_valid & (r_pcnt == 3'd7);
    w_partial   = pi_end & ~w_busy & (r_pcnt != 3'd0);
    w_fill      = pi_end & ~w_busy & (r_pcnt == 3'd0);
    w_last      = r_addr == LAST;
    w_pad       = r_pack << (4'd8 - {1'b0, r_pcnt});
    w_next      = r_wst == WR_IDLE ? ((w_done_byte | w_partial) ? WR_WRITE : w_fill ? WR_FILL : WR_IDLE) :
                  r_wst == WR_DONE ? WR_DONE :
                  r_ph ? (w_last ? WR_DONE : (r_wst == WR_FILL ? WR_FILL : WR_IDLE)) : r_wst;
  end
  always_ff @(posedge clk)
    if (reset) r_wst <= WR_IDLE;
    else r_wst <= w_next;
  always_ff @(posedge clk)
    if (reset) begin
      r_pack   <= '0;
      r_pcnt   <= '0;
      r_dout   <= '0;
      r_addr   <= '0;
      r_ph     <= 1'b0;
      r_wr     <= 1'b0;
      r_finish <= 1'b0;
    end else begin
      if (so_valid) begin
        r_pack <= {r_pack[6:0], so_data};
        r_pcnt <= r_pcnt + 3'd1;
      end else if (r_wst == WR_IDLE && w_partial) begin
        r_pack <= '0;
        r_pcnt <= '0;
      end
      if (r_wst == WR_IDLE)
        r_dout <= w_done_byte ? {r_pack[6:0], so_data} : w_partial ? w_pad : w_fill ? 8'h00 : r_dout;
      if (r_wst == WR_WRITE || r_wst == WR_FILL) begin
        r_wr <= ~r_ph;
        r_ph <= ~r_ph;
        if (r_ph && !w_last) r_addr <= r_addr + 8'd1;
      end
      r_finish <= r_wst == WR_DONE;
    end
  assign pixel_addr    = r_addr;
  assign pixel_dataout = r_dout;
  assign pixel_wr      = r_wr;
  assign pixel_finish  = r_finish;
endmodule

// File: tb/tb_sti_dac.sv
// tb_sti_dac: directed self-checking bench for sti_dac serial frames and pixel memory writes
module tb_sti_dac;
  logic        clk = 1'b0;
  logic        reset, load, pi_fill, pi_msb, pi_low, pi_end;
  logic [15:0] pi_data;
  logic [1:0]  pi_length;
  logic        so_data, so_valid, pixel_wr, pixel_finish;
  logic [7:0]  pixel_addr, pixel_dataout;
  logic [7:0]  mem [256];
  logic [7:0]  exp_a [10] = '{8'hA5, 8'h80, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h12, 8'h34};
  logic [7:0]  exp_b [3]  = '{8'h5A, 8'h70, 8'h96};
  int          n_cmp = 0, n_err = 0, wcnt = 0, wbase = 0;
  always #5 clk = ~clk;
  sti_dac #(.PIX_DEPTH(256)) dut (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .pi_data      (pi_data),
    .pi_length    (pi_length),
    .pi_fill      (pi_fill),
    .pi_msb       (pi_msb),
    .pi_low       (pi_low),
    .pi_end       (pi_end),
    .so_data      (so_data),
    .so_valid     (so_valid),
    .pixel_addr   (pixel_addr),
    .pixel_dataout(pixel_dataout),
    .pixel_wr     (pixel_wr),
    .pixel_finish (pixel_finish)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(posedge pixel_wr) begin
    chk("write_addr", {24'h0, pixel_addr}, 32'(wcnt - wbase));
    mem[pixel_addr] = pixel_dataout;
    wcnt++;
  end
  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1;
    load = 1'b0;
    pi_end = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_so_data", {31'h0, so_data}, 0);
    chk("rst_so_valid", {31'h0, so_valid}, 0);
    chk("rst_addr", {24'h0, pixel_addr}, 0);
    chk("rst_dataout", {24'h0, pixel_dataout}, 0);
    chk("rst_wr", {31'h0, pixel_wr}, 0);
    chk("rst_finish", {31'h0, pixel_finish}, 0);
    wbase = wcnt;
    reset = 1'b0;
  endtask
  task automatic frame(input logic [15:0] d, input logic [1:0] len, input logic fill, input logic msb,
                       input logic low, input logic [31:0] exp, input int nbits, input bit inject, input bit end_mid);
    logic [31:0] bits = '0;
    int n = 0;
    @(negedge clk);
    pi_data = d;
    pi_length = len;
    pi_fill = fill;
    pi_msb = msb;
    pi_low = low;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("valid_rise", {31'h0, so_valid}, 1);
    while (so_valid && n < 40) begin
      bits = {bits[30:0], so_data};
      n++;
      if (inject && n == 3) begin
        pi_data = ~d;
        pi_length = ~len;
        pi_msb = ~msb;
        load = 1'b1;
      end else load = 1'b0;
      if (end_mid && n == 4) pi_end = 1'b1;
      @(negedge clk);
    end
    load = 1'b0;
    chk("bit_count", 32'(n), 32'(nbits));
    chk("frame_bits", bits, exp);
    chk("idle_so_data", {31'h0, so_data}, 0);
  endtask
  task automatic wait_writes(input int target);
    int t = 0;
    while (wcnt - wbase < target && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("write_count", 32'(wcnt - wbase), 32'(target));
  endtask
  initial begin
    int t, nz;
    bit held;
    pi_data = '0;
    pi_length = '0;
    pi_fill = 1'b0;
    pi_msb = 1'b0;
    pi_low = 1'b0;
    do_reset();
    frame(16'hA5C3, 2'b00, 1'b0, 1'b1, 1'b1, 32'h0000_00A5, 8, 1'b0, 1'b0);
    frame(16'h0001, 2'b01, 1'b0, 1'b0, 1'b0, 32'h0000_8000, 16, 1'b0, 1'b0);
    frame(16'hFFFF, 2'b10, 1'b1, 1'b1, 1'b0, 32'h00FF_FF00, 24, 1'b0, 1'b0);
    frame(16'h1234, 2'b11, 1'b0, 1'b1, 1'b0, 32'h0000_1234, 32, 1'b0, 1'b0);
    wait_writes(10);
    for (int i = 0; i < 10; i++) chk($sformatf("pix_a%0d", i), {24'h0, mem[i]}, {24'h0, exp_a[i]});
    chk("finish_early", {31'h0, pixel_finish}, 0);
    repeat (3) @(negedge clk);
    pi_data = 16'hFFFF;
    pi_length = 2'b11;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    do_reset();
    frame(16'h3C5A, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0000_005A, 8, 1'b0, 1'b0);
    frame(16'h0E00, 2'b00, 1'b0, 1'b0, 1'b1, 32'h0000_0070, 8, 1'b1, 1'b0);
    frame(16'h7796, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0000_0096, 8, 1'b0, 1'b1);
    t = 0;
    while (!pixel_finish && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("finish", {31'h0, pixel_finish}, 1);
    chk("total_writes", 32'(wcnt - wbase), 256);
    for (int i = 0; i < 3; i++) chk($sformatf("pix_b%0d", i), {24'h0, mem[i]}, {24'h0, exp_b[i]});
    nz = 0;
    for (int i = 3; i < 256; i++) if (mem[i] !== 8'h00) nz++;
    chk("fill_nonzero", 32'(nz), 0);
    chk("addr_end", {24'h0, pixel_addr}, 255);
    held = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!pixel_finish || pixel_wr) held = 1'b0;
    end
    chk("finish_hold", {31'h0, held}, 1);
    chk("no_more_writes", 32'(wcnt - wbase), 256);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sti_dac.md
STI_DAC -- requirements
Module: sti_dac

Interface
REQ-001 Parameter PIX_DEPTH, default 256: number of pixel-memory locations written before completion.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 load  input  1  one-cycle strobe; captures pi_* descriptor and data.
REQ-005 pi_data  input  16  parallel payload.
REQ-006 pi_length  input  2  frame length: 00=8b, 01=16b, 10=24b, 11=32b.
REQ-007 pi_fill  input  1  24/32b only: 1=payload in upper bits (zeros below), 0=payload in lower bits (zeros above).
REQ-008 pi_msb  input  1  1=frame sent MSB first, 0=LSB first.
REQ-009 pi_low  input  1  8b only: 1=pi_data[15:8], 0=pi_data[7:0].
REQ-010 pi_end  input  1  level; high after the last load, meaning no further frames.
REQ-011 so_data  output  1  serial bit.
REQ-012 so_valid  output  1  high exactly while so_data carries frame bits.
REQ-013 pixel_addr  output  8  pixel-memory write address.
REQ-014 pixel_dataout  output  8  pixel-memory write data.
REQ-015 pixel_wr  output  1  write strobe; memory captures on its rising edge.
REQ-016 pixel_finish  output  1  high once all PIX_DEPTH locations are written.

Function
REQ-017 Frame build at load: 8b = selected byte; 16b = pi_data; 24b = fill ? {pi_data,8'h00} : {8'h00,pi_data}; 32b = fill ? {pi_data,16'h0000} : {16'h0000,pi_data}.
REQ-018 so_valid SHALL rise on the clock edge after the edge sampling load, presenting the first bit; one bit per cycle; exactly 8/16/24/32 cycles; then so_valid low and so_data 0.
REQ-019 load while so_valid is high SHALL be ignored; the bench loads only when idle.
REQ-020 Serializer states: IDLE (wait load), SHIFT (bit counter down to last bit), back to IDLE.
REQ-021 Each transmitted bit SHALL also shift into an 8-bit packer, first bit of each group landing in pixel_dataout[7].
REQ-022 On each 8th packed bit the byte SHALL be written: pixel_dataout/pixel_addr stable one cycle, then pixel_wr high one cycle, then pixel_wr low and pixel_addr incremented.
REQ-023 Addresses SHALL run sequentially from 0; frame boundaries do not realign the packer (total bits are always a multiple of 8).
REQ-024 Writer states: IDLE, WRITE (setup, strobe), FILL, DONE.
REQ-025 When pi_end is high, serializer IDLE and no byte pending, writer SHALL enter FILL: write 8'h00 to every remaining address up to PIX_DEPTH-1 with the same setup/strobe/low pattern.
REQ-026 If pi_end arrives with a partial byte packed, that byte SHALL be zero-padded in its low bits and written before FILL.
REQ-027 After the write of address PIX_DEPTH-1 completes (pixel_wr falls), pixel_finish SHALL go high next cycle and stay high until reset; no further writes; pixel_addr does not wrap.
REQ-028 pi_end high before the last frame finishes SHALL only take effect after that frame's final byte write.

Reset
REQ-029 reset SHALL force so_data=0, so_valid=0, pixel_addr=0, pixel_dataout=0, pixel_wr=0, pixel_finish=0, all FSMs IDLE, counters/packer cleared; reset mid-frame or mid-fill aborts the operation.

Structure
REQ-030 Shared package sti_dac_pkg SHALL hold length encodings (LEN_8/16/24/32), bit counts per length, and FSM state enums.
REQ-031 One sub-module sti_serializer (frame build + shift + so_valid); packer/pixel writer stays in sti_dac.

Verification
REQ-032 pi_data=16'hA5C3, len=00, low=1, msb=1 -> so_data 1,0,1,0,0,1,0,1 over 8 valid cycles; pixel[0]=8'hA5.
REQ-033 pi_data=16'h0001, len=01, msb=0 -> first bit 1 then fifteen 0s; pixels get 8'h80, 8'h00.
REQ-034 pi_data=16'hFFFF, len=10, fill=1, msb=1 -> sixteen 1s then eight 0s; so_valid 24 cycles.
REQ-035 pi_data=16'h1234, len=11, fill=0, msb=1 -> sixteen 0s then 0001_0010_0011_0100; 32 valid cycles.
REQ-036 Three 8b frames then pi_end -> pixels 0..2 hold frames, 3..255 = 8'h00, pixel_finish high and stays high; load during so_valid has no effect.
